// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction-fetch and data ports, with stall generation.
// Define ARB_FAIRNESS_EN to let a starved fetch win after STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                busy
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;   // 1 = data port owns the access
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic                if_ready_q, if_ready_d, d_ready_q, d_ready_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic                grant_data;

`ifdef ARB_FAIRNESS_EN
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    logic [SW-1:0] starve_q, starve_d;

    // Counts data grants that bypassed a waiting fetch; fetch wins once it hits the limit.
    always_comb begin
        starve_d   = starve_q;
        grant_data = d_req;
        if (state_q == IDLE && (if_req || d_req)) begin
            if (d_req && if_req && starve_q == SW'(STARVE_MAX)) begin
                grant_data = 1'b0;
                starve_d   = '0;
            end else if (d_req && if_req) begin
                starve_d = starve_q + 1'b1;
            end else begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`else
    assign grant_data = d_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_d  = grant_data;
                    mem_en_d = 1'b1;
                    cnt_d    = CNT_W'(MEM_LAT - 1);
                    state_d  = BUSY;
                    if (grant_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_be_d    = d_we ? d_be : '0;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!mem_we_q) begin
                        if (owner_q) d_rdata_d  = mem_rdata;
                        else         if_rdata_d = mem_rdata;
                    end
                    if (owner_q) d_ready_d  = 1'b1;
                    else         if_ready_d = 1'b1;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    mem_be_d = '0;
                    state_d  = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    // Stalls use the registered ready so the hazard unit sees no extra delay.
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level timing model plus a latency-accurate memory.
// Expectations follow ARB_FAIRNESS_EN the same way the design does.
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        if_ready, d_ready, mem_en, mem_we, stall_if, stall_mem, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 16) return 32'h0050_0093;
        return (i * 32'h0101_0101) ^ 32'h5A00_0000;
    endfunction

    // Memory: data only valid on the MEM_LAT-th cycle of mem_en, junk otherwise.
    logic [31:0] phys [256];
    bit          init_done = 1'b0;
    int          en_cnt;
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) phys[i] <= init_word(i);
            init_done <= 1'b1;
        end else if (mem_en && mem_we && en_cnt == MEM_LAT - 1) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) phys[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) en_cnt <= 0;
        else        en_cnt <= mem_en ? en_cnt + 1 : 0;
    end
    assign mem_rdata = (mem_en && en_cnt == MEM_LAT - 1) ? phys[mem_addr[9:2]] : 32'hA5A5_5A5A;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        iq[$], dq[$];
    logic [31:0] ref_mem [256];
    int          n_checks = 0, n_err = 0;
    int          cyc = 0, igap = 0, dgap = 0;
    bit          rnd_gap = 0;

    // Transaction model: grant cycle g -> mem_en g+1..g+MEM_LAT, ready g+MEM_LAT+1, idle g+MEM_LAT+2.
    bit          m_act = 0, m_port = 0, m_we = 0;
    int          m_g = 0, m_starve = 0;
    logic [31:0] m_addr, m_wdata, m_rd, e_ird = '0, e_drd = '0;
    logic [3:0]  m_be;
    bit          e_irdy, e_drdy;

    bit          starve_ph = 0, seen_if = 0;
    int          d_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic grant(input bit data);
        txn_t t;
        m_act = 1; m_g = cyc; m_port = data;
        if (data) begin
            t = dq[0];
            m_we = t.we; m_addr = t.addr; m_wdata = t.wdata; m_be = t.be;
        end else begin
            t = iq[0];
            m_we = 0; m_addr = t.addr; m_wdata = '0; m_be = '0;
        end
        if (m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) ref_mem[m_addr[9:2]][b*8 +: 8] = m_wdata[b*8 +: 8];
        end else begin
            m_rd = ref_mem[m_addr[9:2]];
        end
    endtask

    task automatic step();
        bit e_en, e_busy, e_rdy;
        @(posedge clk); #1;
        cyc++;
        e_en   = m_act && cyc >= m_g + 1 && cyc <= m_g + MEM_LAT;
        e_rdy  = m_act && cyc == m_g + MEM_LAT + 1;
        e_busy = m_act && cyc >= m_g + 1 && cyc <= m_g + MEM_LAT + 1;
        e_irdy = e_rdy && !m_port;
        e_drdy = e_rdy && m_port;
        if (e_rdy && !m_we) begin
            if (m_port) e_drd = m_rd;
            else        e_ird = m_rd;
        end
        chk("busy", busy, e_busy);
        chk("mem_en", mem_en, e_en);
        chk("mem_we", mem_we, e_en && m_we);
        chk("if_ready", if_ready, e_irdy);
        chk("d_ready", d_ready, e_drdy);
        chk("if_rdata", if_rdata, e_ird);
        chk("d_rdata", d_rdata, e_drd);
        if (e_en) chk("mem_addr", mem_addr, m_addr);
        if (e_en && m_we) begin
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_be", mem_be, m_be);
        end
        if (!e_en) chk("mem_be_idle", mem_be, 4'h0);
        if (starve_ph) begin
            if (d_ready) d_done++;
            if (if_ready && !seen_if) begin
                seen_if = 1;
`ifdef ARB_FAIRNESS_EN
                chk("starve_order", d_done, STARVE_MAX);
`else
                chk("starve_order", d_done, 8);
`endif
            end
        end
        if (m_act && cyc >= m_g + MEM_LAT + 2) m_act = 0;

        // Requesters drop on their ready pulse and re-raise from the next cycle.
        if (e_irdy) begin
            if_req = 0; void'(iq.pop_front()); igap = rnd_gap ? $urandom_range(0, 2) : 0;
        end else if (!if_req) begin
            if (igap > 0) igap--;
            else if (iq.size() != 0) begin if_req = 1; if_addr = iq[0].addr; end
        end
        if (e_drdy) begin
            d_req = 0; void'(dq.pop_front()); dgap = rnd_gap ? $urandom_range(0, 2) : 0;
        end else if (!d_req) begin
            if (dgap > 0) dgap--;
            else if (dq.size() != 0) begin
                d_req = 1; d_we = dq[0].we; d_addr = dq[0].addr; d_wdata = dq[0].wdata; d_be = dq[0].be;
            end
        end

        if (!m_act && (if_req || d_req)) begin
            if (if_req && d_req) begin
`ifdef ARB_FAIRNESS_EN
                if (m_starve == STARVE_MAX) begin grant(0); m_starve = 0; end
                else begin grant(1); m_starve++; end
`else
                grant(1);
`endif
            end else begin
                grant(d_req);
                m_starve = 0;
            end
        end
        #1;
        chk("stall_if", stall_if, if_req && !e_irdy);
        chk("stall_mem", stall_mem, d_req && !e_drdy);
    endtask

    task automatic drain(input int max);
        int k = 0;
        while ((iq.size() != 0 || dq.size() != 0 || m_act) && k < max) begin
            step(); k++;
        end
        chk("drain_done", (iq.size() != 0 || dq.size() != 0 || m_act), 0);
    endtask

    task automatic push_d(input logic we, input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = w; t.be = be;
        dq.push_back(t);
    endtask

    task automatic push_i(input logic [31:0] a);
        txn_t t;
        t.we = 0; t.addr = a; t.wdata = '0; t.be = '0;
        iq.push_back(t);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rdy"}, {if_ready, d_ready}, 0);
        chk({tag, "_rdata"}, {if_rdata, d_rdata}, 0);
        chk({tag, "_mem"}, {mem_we, mem_be, mem_addr}, 0);
    endtask

    initial begin
        rst_n = 0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;

        // Fetch read at 0x40.
        push_i(32'h40);
        drain(50);

        // Data write then read-back of the same word.
        push_d(1, 32'h100, 32'hDEAD_BEEF, 4'hF);
        push_d(0, 32'h100, '0, '0);
        drain(50);
        chk("wr_rd_value", d_rdata, 32'hDEAD_BEEF);

        // Partial-byte write then fetch of the same word.
        push_d(1, 32'h104, 32'h1122_3344, 4'b0101);
        drain(50);
        push_i(32'h104);
        drain(50);

        // Simultaneous requests: data first, fetch right after.
        push_i(32'h8);
        push_d(0, 32'hC, '0, '0);
        drain(50);

        // Reset in the middle of a data read.
        push_d(0, 32'h100, '0, '0);
        while (!(m_act && cyc == m_g + 1) && dq.size() != 0) step();
        #1 rst_n = 0;
        #1;
        chk_zero("midrst");
        d_req = 0; dq.delete(); iq.delete();
        m_act = 0; m_starve = 0; e_ird = '0; e_drd = '0;
        repeat (2) step();
        rst_n = 1;
        push_d(0, 32'h100, '0, '0);
        drain(50);

        // Starvation: fetch waits behind a stream of data requests.
        starve_ph = 1; d_done = 0; seen_if = 0;
        for (int i = 0; i < 8; i++) push_d(0, 32'(i * 4), '0, '0);
        push_i(32'h20);
        drain(200);
        chk("starve_seen", seen_if, 1);
        starve_ph = 0;

        // Randomized traffic on both ports.
        rnd_gap = 1;
        for (int i = 0; i < 40; i++)
            push_d($urandom_range(0, 1), 32'($urandom_range(0, 15) * 4), $urandom, 4'($urandom_range(0, 15)));
        for (int i = 0; i < 30; i++)
            push_i(32'($urandom_range(0, 15) * 4));
        drain(2000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
